// File: rtl/fp_align_pkg.sv
// Shared widths, format presets and the S1->S2 flag record for the FP align pipe.
// Optional feature macro (used by fp_align_pipe): FP_ALIGN_FLUSH_DENORM_EN.
package fp_align_pkg;

  function automatic int ext_w(input int mant_w);
    return mant_w + 3;
  endfunction

  function automatic int op_w(input int exp_w, input int mant_w);
    return 1 + exp_w + mant_w;
  endfunction

  // Format presets packed as {EXP_W, MANT_W}
  localparam logic [15:0] FMT_FP16 = {8'd5, 8'd10};
  localparam logic [15:0] FMT_FP32 = {8'd8, 8'd23};
  localparam logic [15:0] FMT_FP64 = {8'd11, 8'd52};

  localparam int EXT_W = ext_w(int'(FMT_FP32[7:0]));
  localparam int OP_W  = op_w(int'(FMT_FP32[15:8]), int'(FMT_FP32[7:0]));

  typedef struct packed {
    logic exc;
    logic nan;
    logic swap;
    logic signBig;
    logic signSmall;
  } s1_flags_t;

endpackage

// File: rtl/fp_align_pipe_shift.sv
// Saturating right shifter for the small mantissa; sticky collects every bit shifted out.
module fp_shift_sticky #(
  parameter int EXT_W = 26,
  parameter int SH_W  = 8
) (
  input  logic [EXT_W-1:0] data_i,
  input  logic [SH_W-1:0]  shamt_i,
  output logic [EXT_W-1:0] data_o,
  output logic             sticky_o
);

  logic [EXT_W-1:0] lowMask;

  always_comb begin
    data_o   = '0;
    sticky_o = 1'b0;
    lowMask  = ~({EXT_W{1'b1}} << shamt_i);
    if (32'(shamt_i) >= 32'(EXT_W)) begin
      sticky_o = |data_i;
    end else begin
      data_o   = data_i >> shamt_i;
      sticky_o = |(data_i & lowMask);
    end
  end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage elastic FP align: S1 classifies/orders operands, S2 shifts the small mantissa.
// Define FP_ALIGN_FLUSH_DENORM_EN to flush subnormal operands to signed zero.
module fp_align_pipe
  import fp_align_pkg::*;
#(
  parameter int EXP_W  = int'(FMT_FP32[15:8]),
  parameter int MANT_W = int'(FMT_FP32[7:0])
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [EXP_W+MANT_W:0] in_a_i,
  input  logic [EXP_W+MANT_W:0] in_b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [EXP_W-1:0]      out_exp_o,
  output logic [MANT_W+2:0]     out_mant_big_o,
  output logic [MANT_W+2:0]     out_mant_small_o,
  output logic                  out_sticky_o,
  output logic                  out_sign_big_o,
  output logic                  out_sign_small_o,
  output logic                  out_swap_o,
  output logic                  out_exc_o,
  output logic                  out_nan_o
);

  localparam int EW = ext_w(MANT_W);
  localparam int OW = op_w(EXP_W, MANT_W);

  logic              signA, signB, hidA, hidB, excA, excB, infA, infB, aBig;
  logic [EXP_W-1:0]  expA, expB, effA, effB;
  logic [MANT_W-1:0] fracA, fracB;

  s1_flags_t         s1Flags_d, s1Flags_q, outFlags_q;
  logic [EXP_W-1:0]  s1Exp_d, s1Exp_q, s1Diff_d, s1Diff_q, outExp_q;
  logic [MANT_W:0]   s1Big_d, s1Big_q, s1Small_d, s1Small_q;
  logic              s1Valid_q, outValid_q, outSticky_q, s1Load, s2Load;
  logic [EW-1:0]     outMantBig_q, outMantSmall_q, shiftedSmall;
  logic              shiftSticky;

  assign s2Load     = ~outValid_q | out_ready_i;
  assign s1Load     = ~s1Valid_q | s2Load;
  assign in_ready_o = s1Load;

  always_comb begin
    signA = in_a_i[OW-1];
    signB = in_b_i[OW-1];
    expA  = in_a_i[OW-2 -: EXP_W];
    expB  = in_b_i[OW-2 -: EXP_W];
    fracA = in_a_i[MANT_W-1:0];
    fracB = in_b_i[MANT_W-1:0];
`ifdef FP_ALIGN_FLUSH_DENORM_EN
    if (expA == '0) fracA = '0;
    if (expB == '0) fracB = '0;
`endif
    hidA = |expA;
    hidB = |expB;
    effA = (expA == '0) ? EXP_W'(1) : expA;
    effB = (expB == '0) ? EXP_W'(1) : expB;
    excA = &expA;
    excB = &expB;
    infA = excA & ~|fracA;
    infB = excB & ~|fracB;
    // Equal effective exponents fall back to the full significand so exp 0 vs 1 orders correctly
    aBig = (effA > effB) | ((effA == effB) & ({hidA, fracA} >= {hidB, fracB}));

    s1Flags_d.exc       = excA | excB;
    s1Flags_d.nan       = (excA & |fracA) | (excB & |fracB) | (infA & infB & (signA ^ signB));
    s1Flags_d.swap      = ~aBig;
    s1Flags_d.signBig   = aBig ? signA : signB;
    s1Flags_d.signSmall = aBig ? signB : signA;

    s1Exp_d   = aBig ? expA : expB;
    s1Diff_d  = aBig ? (effA - effB) : (effB - effA);
    s1Big_d   = aBig ? {hidA, fracA} : {hidB, fracB};
    s1Small_d = aBig ? {hidB, fracB} : {hidA, fracA};
    if (s1Flags_d.exc) begin
      s1Exp_d   = '1;
      s1Diff_d  = '0;
      s1Big_d   = '0;
      s1Small_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Flags_q <= '0;
      s1Exp_q   <= '0;
      s1Diff_q  <= '0;
      s1Big_q   <= '0;
      s1Small_q <= '0;
    end else if (s1Load) begin
      s1Valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1Flags_q <= s1Flags_d;
        s1Exp_q   <= s1Exp_d;
        s1Diff_q  <= s1Diff_d;
        s1Big_q   <= s1Big_d;
        s1Small_q <= s1Small_d;
      end
    end
  end

  fp_shift_sticky #(
    .EXT_W (EW),
    .SH_W  (EXP_W)
  ) u_shift (
    .data_i   ({s1Small_q, 2'b00}),
    .shamt_i  (s1Diff_q),
    .data_o   (shiftedSmall),
    .sticky_o (shiftSticky)
  );

  // Bubbles only clear the valid flag so a drained output keeps its last data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q     <= 1'b0;
      outFlags_q     <= '0;
      outExp_q       <= '0;
      outMantBig_q   <= '0;
      outMantSmall_q <= '0;
      outSticky_q    <= 1'b0;
    end else if (s2Load) begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        outFlags_q     <= s1Flags_q;
        outExp_q       <= s1Exp_q;
        outMantBig_q   <= {s1Big_q, 2'b00};
        outMantSmall_q <= shiftedSmall;
        outSticky_q    <= shiftSticky;
      end
    end
  end

  assign out_valid_o      = outValid_q;
  assign out_exp_o        = outExp_q;
  assign out_mant_big_o   = outMantBig_q;
  assign out_mant_small_o = outMantSmall_q;
  assign out_sticky_o     = outSticky_q;
  assign out_sign_big_o   = outFlags_q.signBig;
  assign out_sign_small_o = outFlags_q.signSmall;
  assign out_swap_o       = outFlags_q.swap;
  assign out_exc_o        = outFlags_q.exc;
  assign out_nan_o        = outFlags_q.nan;

endmodule
